fx_reg_bank: RTL

//  Parametrised fx-bus register bank for any module slot: NUM_CFG RW config regs, NUM_STA RO status regs,
//  and an 8-bit sticky interrupt block (pending W1C, mask, force) driving one irq line.

---
 rtl/fx_reg_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fx_reg_bank.sv
// fx_reg_bank: per-slot fx-bus register bank with RW config, RO status and a sticky irq block.
// Revision: 1.0
`default_nettype none

module fx_reg_bank #(
  parameter int         NUM_CFG  = 8,
  parameter logic [7:0] CFG_BASE = 8'h80,
  parameter int         NUM_STA  = 4,
  parameter logic [7:0] STA_BASE = 8'h40,
  parameter logic [7:0] VERSION  = 8'h02
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [15:0]          fx_waddr,
  input  logic                 fx_wr,
  input  logic [7:0]           fx_data,
  input  logic [15:0]          fx_raddr,
  input  logic                 fx_rd,
  output logic [7:0]           fx_q,
  input  logic [5:0]           mod_id,
  output logic [NUM_CFG*8-1:0] cfg_flat,
  output logic [NUM_CFG-1:0]   cfg_wstb,
  input  logic [NUM_STA*8-1:0] sta_flat,
  input  logic [7:0]           irq_src,
  output logic                 irq_out
);

  localparam logic [7:0] ADDR_ID    = 8'h00;
  localparam logic [7:0] ADDR_VER   = 8'h01;
  localparam logic [7:0] ADDR_PEND  = 8'h10;
  localparam logic [7:0] ADDR_MASK  = 8'h11;
  localparam logic [7:0] ADDR_FORCE = 8'h12;
  localparam int         FIXED_HI   = 'h12;

  localparam int CFG_LO = int'(CFG_BASE);
  localparam int CFG_HI = CFG_LO + NUM_CFG - 1;
  localparam int STA_LO = int'(STA_BASE);
  localparam int STA_HI = STA_LO + NUM_STA - 1;

  function automatic logic [NUM_CFG*8-1:0] cfg_reset_value();
    logic [NUM_CFG*8-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      v[8*i +: 8] = 8'(CFG_LO + i);
    end
    return v;
  endfunction

  localparam logic [NUM_CFG*8-1:0] CFG_RST = cfg_reset_value();

  // Address map sanity, caught at elaboration.
  if (NUM_CFG < 1 || NUM_CFG > 64) begin : g_bad_num_cfg
    $error("fx_reg_bank: NUM_CFG out of range 1..64");
  end
  if (NUM_STA < 1 || NUM_STA > 32) begin : g_bad_num_sta
    $error("fx_reg_bank: NUM_STA out of range 1..32");
  end
  if (CFG_LO <= STA_HI && STA_LO <= CFG_HI) begin : g_cfg_sta_overlap
    $error("fx_reg_bank: config and status ranges overlap");
  end
  if (CFG_LO <= FIXED_HI) begin : g_cfg_fixed_overlap
    $error("fx_reg_bank: config range overlaps fixed registers 0x00-0x12");
  end
  if (STA_LO <= FIXED_HI) begin : g_sta_fixed_overlap
    $error("fx_reg_bank: status range overlaps fixed registers 0x00-0x12");
  end

  logic                 now_wr;
  logic                 now_rd;
  logic [7:0]           wreg;
  logic [7:0]           rreg;
  logic                 unused_addr_bits;

  logic [NUM_CFG*8-1:0] cfg_q, cfg_d;
  logic [NUM_CFG-1:0]   cfg_wstb_q, cfg_wstb_d;
  logic [7:0]           irq_pend_q, irq_pend_d;
  logic [7:0]           irq_mask_q, irq_mask_d;
  logic                 irq_out_q, irq_out_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [7:0]           pend_clr;
  logic [7:0]           pend_force;

  assign now_wr = fx_wr & (fx_waddr[13:8] == mod_id);
  assign now_rd = fx_rd & (fx_raddr[13:8] == mod_id);
  assign wreg   = fx_waddr[7:0];
  assign rreg   = fx_raddr[7:0];
  assign unused_addr_bits = ^{fx_waddr[15:14], fx_raddr[15:14]};

  always_comb begin
    cfg_d      = cfg_q;
    cfg_wstb_d = '0;
    irq_mask_d = irq_mask_q;
    pend_clr   = '0;
    pend_force = '0;
    if (now_wr) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (wreg == 8'(CFG_LO + i)) begin
          cfg_d[8*i +: 8] = fx_data;
          cfg_wstb_d[i]   = 1'b1;
        end
      end
      if (wreg == ADDR_PEND)  pend_clr   = fx_data;
      if (wreg == ADDR_MASK)  irq_mask_d = fx_data;
      if (wreg == ADDR_FORCE) pend_force = fx_data;
    end
    // New events are OR-ed in after the clear so a coincident set is never lost.
    irq_pend_d = (irq_pend_q & ~pend_clr) | irq_src | pend_force;
    irq_out_d  = |(irq_pend_q & irq_mask_q);
  end

  always_comb begin
    rdata_d = '0;
    if (now_rd) begin
      if (rreg == ADDR_ID)   rdata_d = {2'b00, mod_id};
      if (rreg == ADDR_VER)  rdata_d = VERSION;
      if (rreg == ADDR_PEND) rdata_d = irq_pend_q;
      if (rreg == ADDR_MASK) rdata_d = irq_mask_q;
      for (int i = 0; i < NUM_CFG; i++) begin
        if (rreg == 8'(CFG_LO + i)) rdata_d = cfg_q[8*i +: 8];
      end
      for (int j = 0; j < NUM_STA; j++) begin
        if (rreg == 8'(STA_LO + j)) rdata_d = sta_flat[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= CFG_RST;
      cfg_wstb_q <= '0;
      irq_pend_q <= '0;
      irq_mask_q <= '0;
      irq_out_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cfg_q      <= cfg_d;
      cfg_wstb_q <= cfg_wstb_d;
      irq_pend_q <= irq_pend_d;
      irq_mask_q <= irq_mask_d;
      irq_out_q  <= irq_out_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cfg_flat = cfg_q;
  assign cfg_wstb = cfg_wstb_q;
  assign irq_out  = irq_out_q;
  assign fx_q     = rdata_q;

endmodule

`default_nettype wire
